// File: rtl/usb_rx_pkt_ctrl_pkg.sv
// Shared types and constants for the USB 1.1 full-speed receive packet path.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        DATA,
        DONE,
        ERR
    } rx_state_t;

    // First byte on the wire, assembled LSB-first
    localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;

    // PID nibbles as carried in rx_byte[3:0]
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // PID byte is valid when the upper nibble is the complement of the lower
    function automatic logic pid_check_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

endpackage

// File: rtl/usb_rx_pkt_ctrl_if.sv
// Front-end to packet-controller bus: byte strobes in, PID controls and data out.
interface usb_rx_pkt_ctrl_if #(
    parameter int unsigned CNT_W = 7
);
    logic             d_edge;
    logic             byte_valid;
    logic [7:0]       rx_byte;
    logic             eop;
    logic             bit_err;
    logic             pid_set;
    logic             pid_rst;
    logic [3:0]       pid_in;
    logic [7:0]       rx_data;
    logic             rx_data_valid;
    logic [CNT_W-1:0] byte_cnt;
    logic             rx_packet_done;
    logic             rx_err;
    logic             receiving;

    // Front end / downstream side
    modport master (
        output d_edge, byte_valid, rx_byte, eop, bit_err,
        input  pid_set, pid_rst, pid_in, rx_data, rx_data_valid,
               byte_cnt, rx_packet_done, rx_err, receiving
    );

    // Packet controller side
    modport slave (
        input  d_edge, byte_valid, rx_byte, eop, bit_err,
        output pid_set, pid_rst, pid_in, rx_data, rx_data_valid,
               byte_cnt, rx_packet_done, rx_err, receiving
    );
endinterface

// File: rtl/usb_rx_pkt_ctrl_rx_byte_counter.sv
// Saturating data-byte counter with synchronous clear and terminal flag.
module rx_byte_counter #(
    parameter int unsigned MAX_BYTES = 66,
    parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    assign at_max = (cnt == CNT_W'(MAX_BYTES));

    // Count enabled bytes, holding at MAX_BYTES
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// Receive packet controller: SYNC/PID validation, data byte pass-through,
// packet completion and error reporting.
module usb_rx_pkt_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int unsigned MAX_BYTES = 66,
    parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input logic             clk,
    input logic             rst,
    usb_rx_pkt_ctrl_if.slave bus
);

    rx_state_t        state;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_max;
    logic [CNT_W-1:0] cnt;

    // Counter controls follow the same conditions the FSM uses to accept a byte
    always_comb begin
        cnt_clr = (state == IDLE) && bus.d_edge;
        cnt_en  = (state == DATA) && bus.byte_valid && !bus.bit_err && !cnt_max;
    end

    rx_byte_counter #(
        .MAX_BYTES (MAX_BYTES),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .cnt    (cnt),
        .at_max (cnt_max)
    );

    assign bus.byte_cnt = cnt;

    // Packet FSM with registered outputs; receiving is tracked alongside
    // each transition so it stays a flop rather than a state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            bus.pid_set        <= 1'b0;
            bus.pid_rst        <= 1'b0;
            bus.pid_in         <= 4'hF;
            bus.rx_data        <= '0;
            bus.rx_data_valid  <= 1'b0;
            bus.rx_packet_done <= 1'b0;
            bus.rx_err         <= 1'b0;
            bus.receiving      <= 1'b0;
        end else begin
            bus.pid_set        <= 1'b0;
            bus.pid_rst        <= 1'b0;
            bus.rx_data_valid  <= 1'b0;
            bus.rx_packet_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.d_edge) begin
                        state         <= SYNC;
                        bus.pid_rst   <= 1'b1;
                        bus.rx_err    <= 1'b0;
                        bus.receiving <= 1'b1;
                    end
                end
                SYNC: begin
                    if (bus.bit_err) begin
                        state         <= ERR;
                        bus.pid_rst   <= 1'b1;
                        bus.rx_err    <= 1'b1;
                        bus.receiving <= 1'b0;
                    end else if (bus.byte_valid && !bus.eop && bus.rx_byte == SYNC_BYTE) begin
                        state <= PID;
                    end else if (bus.byte_valid || bus.eop) begin
                        state         <= ERR;
                        bus.rx_err    <= 1'b1;
                        bus.receiving <= 1'b0;
                    end
                end
                PID: begin
                    if (bus.bit_err) begin
                        state         <= ERR;
                        bus.pid_rst   <= 1'b1;
                        bus.rx_err    <= 1'b1;
                        bus.receiving <= 1'b0;
                    end else if (bus.byte_valid && !bus.eop) begin
                        bus.pid_in <= bus.rx_byte[3:0];
                        if (pid_check_ok(bus.rx_byte)) begin
                            state       <= DATA;
                            bus.pid_set <= 1'b1;
                        end else begin
                            state         <= ERR;
                            bus.pid_rst   <= 1'b1;
                            bus.rx_err    <= 1'b1;
                            bus.receiving <= 1'b0;
                        end
                    end else if (bus.byte_valid || bus.eop) begin
                        state         <= ERR;
                        bus.rx_err    <= 1'b1;
                        bus.receiving <= 1'b0;
                    end
                end
                DATA: begin
                    if (bus.bit_err) begin
                        state         <= ERR;
                        bus.pid_rst   <= 1'b1;
                        bus.rx_err    <= 1'b1;
                        bus.receiving <= 1'b0;
                    end else if (bus.byte_valid && cnt_max) begin
                        state         <= ERR;
                        bus.rx_err    <= 1'b1;
                        bus.receiving <= 1'b0;
                    end else begin
                        if (bus.byte_valid) begin
                            bus.rx_data       <= bus.rx_byte;
                            bus.rx_data_valid <= 1'b1;
                        end
                        if (bus.eop) begin
                            state         <= DONE;
                            bus.receiving <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    bus.rx_packet_done <= 1'b1;
                    state              <= IDLE;
                end
                ERR: begin
                    if (bus.eop) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
